// File: rtl/rand_matrix_ctrl.sv
// Fills matrix storage row-major with random elements bounded to 0..max_val,
// retrying out-of-range samples and forcing a masked write after RETRY_MAX rejections.
module rand_matrix_ctrl #(
    parameter int MAX_DIM   = 5,
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 5,
    parameter int RETRY_MAX = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        rows,
    input  logic [2:0]        cols,
    input  logic [DATA_W-1:0] max_val,
    input  logic [DATA_W-1:0] rand_in,
    output logic              rand_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int         RW        = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [2:0] MAX_DIM_L = 3'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              dims_ok;
    logic [5:0]        prod;
    logic              take;
    logic [DATA_W-1:0] sample;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        max_d     = max_q;
        addr_d    = addr_q;
        retry_d   = retry_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        take      = 1'b0;
        sample    = rand_in;
        dims_ok   = (rows != 3'd0) && (rows <= MAX_DIM_L) &&
                    (cols != 3'd0) && (cols <= MAX_DIM_L);
        prod      = {3'b000, rows} * {3'b000, cols};

        case (state_q)
            IDLE: begin
                // busy_q still high here means the done pulse is showing; starts then are ignored
                if (start && !busy_q) begin
                    if (dims_ok) begin
                        last_d  = ADDR_W'(prod - 6'd1);
                        max_d   = max_val;
                        addr_d  = '0;
                        retry_d = '0;
                        state_d = GEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GEN: begin
                busy_d = 1'b1;
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (rand_in <= max_q) begin
                        take = 1'b1;
                    end else if (retry_q == RW'(RETRY_MAX)) begin
                        // masking with the bound can never exceed it
                        take   = 1'b1;
                        sample = rand_in & max_q;
                    end else begin
                        retry_d = retry_q + RW'(1);
                    end
                    if (take) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = sample;
                        retry_d   = '0;
                        addr_d    = addr_q + ADDR_W'(1);
                        if (addr_q == last_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= '0;
            max_q     <= '0;
            addr_q    <= '0;
            retry_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            max_q     <= max_d;
            addr_q    <= addr_d;
            retry_q   <= retry_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign rand_en = (state_q == GEN);
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_rand_matrix_ctrl.sv
// Directed and randomized bench for rand_matrix_ctrl; expected writes come from a
// sample-list model applying the accept / retry / forced-write rules.
module tb_rand_matrix_ctrl;

    localparam int RETRY_MAX = 7;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [2:0] rows, cols;
    logic [3:0] max_val, rand_in;
    logic       rand_en, wr_en, busy, done, err;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;

    int total = 0;
    int fails = 0;

    logic [3:0] seq   [256];
    bit         exp_we[256];
    logic [3:0] exp_d [256];

    rand_matrix_ctrl #(
        .MAX_DIM(5), .DATA_W(4), .ADDR_W(5), .RETRY_MAX(RETRY_MAX)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rows(rows), .cols(cols), .max_val(max_val), .rand_in(rand_in),
        .rand_en(rand_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the sample list: each sample is accepted, counted as a retry, or forced.
    task automatic model(input int n, input logic [3:0] m, output int nsamp);
        int retry;
        int w;
        int i;
        retry = 0;
        w = 0;
        i = 0;
        while (w < n && i < 256) begin
            if (seq[i] <= m) begin
                exp_we[i] = 1'b1; exp_d[i] = seq[i]; w++; retry = 0;
            end else if (retry == RETRY_MAX) begin
                exp_we[i] = 1'b1; exp_d[i] = seq[i] & m; w++; retry = 0;
            end else begin
                exp_we[i] = 1'b0; exp_d[i] = 4'd0; retry++;
            end
            i++;
        end
        nsamp = i;
    endtask

    task automatic run_fill(input logic [2:0] r, input logic [2:0] c, input logic [3:0] m,
                            input string tag);
        int nsamp;
        int waddr;
        model(int'(r) * int'(c), m, nsamp);
        start = 1'b1; rows = r; cols = c; max_val = m; rand_in = seq[0];
        tick();
        start = 1'b0;
        rows = 3'($urandom); cols = 3'($urandom); max_val = 4'($urandom);
        chk({tag, "_rand_en_gen"}, 32'(rand_en), 32'd1);
        waddr = 0;
        for (int k = 1; k <= nsamp; k++) begin
            tick();
            chk({tag, "_wr_en"}, 32'(wr_en), 32'(exp_we[k-1]));
            if (exp_we[k-1]) begin
                chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(waddr));
                chk({tag, "_wr_data"}, 32'(wr_data), 32'(exp_d[k-1]));
                waddr++;
            end
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_done_early"}, 32'(done), 32'd0);
            chk({tag, "_rand_en"}, 32'(rand_en), (k < nsamp) ? 32'd1 : 32'd0);
            if (k < 256) rand_in = seq[k];
        end
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        chk({tag, "_wr_en_done"}, 32'(wr_en), 32'd0);
        tick();
        chk({tag, "_done_clear"}, 32'(done), 32'd0);
        chk({tag, "_busy_clear"}, 32'(busy), 32'd0);
    endtask

    task automatic fill_random_seq();
        for (int i = 0; i < 256; i++) seq[i] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        rows = 3'd0; cols = 3'd0; max_val = 4'd0; rand_in = 4'd0;
        tick(); tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rand_en", 32'(rand_en), 32'd0);
        rst = 1'b0;
        tick();

        // 2x3, everything accepted
        for (int i = 0; i < 256; i++) seq[i] = 4'((i % 6) + 1);
        run_fill(3'd2, 3'd3, 4'd15, "fill2x3");

        // two rejects, then an accepted 3
        for (int i = 0; i < 256; i++) seq[i] = 4'd3;
        seq[0] = 4'd9; seq[1] = 4'd9;
        run_fill(3'd1, 3'd1, 4'd5, "retry");

        // persistent out-of-range value forces 14 & 5 = 4
        for (int i = 0; i < 256; i++) seq[i] = 4'd14;
        run_fill(3'd1, 3'd1, 4'd5, "forced");

        // illegal dimensions
        start = 1'b1; rows = 3'd0; cols = 3'd3; max_val = 4'd9;
        tick();
        start = 1'b0;
        chk("err_rows0", 32'(err), 32'd1);
        chk("err_rows0_busy", 32'(busy), 32'd0);
        chk("err_rows0_rand_en", 32'(rand_en), 32'd0);
        tick();
        chk("err_rows0_clear", 32'(err), 32'd0);
        chk("err_rows0_wr_en", 32'(wr_en), 32'd0);
        start = 1'b1; rows = 3'd2; cols = 3'd6;
        tick();
        start = 1'b0;
        chk("err_cols6", 32'(err), 32'd1);
        chk("err_cols6_busy", 32'(busy), 32'd0);
        tick();
        chk("err_cols6_clear", 32'(err), 32'd0);
        chk("err_cols6_wr_en", 32'(wr_en), 32'd0);

        // abort after the third write, with a start pulse while busy
        start = 1'b1; rows = 3'd2; cols = 3'd2; max_val = 4'd15;
        rand_in = 4'($urandom_range(0, 15));
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("abort_wr_en", 32'(wr_en), 32'd1);
            chk("abort_wr_addr", 32'(wr_addr), 32'(k - 1));
            rand_in = 4'($urandom_range(0, 15));
        end
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_no_write", 32'(wr_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rand_en", 32'(rand_en), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_idle_wr_en", 32'(wr_en), 32'd0);
            chk("abort_idle_done", 32'(done), 32'd0);
            chk("abort_idle_busy", 32'(busy), 32'd0);
            chk("abort_idle_rand_en", 32'(rand_en), 32'd0);
        end

        // asynchronous reset mid-fill, then a fresh fill
        start = 1'b1; rows = 3'd3; cols = 3'd3; max_val = 4'd15;
        rand_in = 4'd7;
        tick();
        start = 1'b0;
        tick();
        chk("rstmid_wr0", 32'(wr_addr), 32'd0);
        rand_in = 4'd11;
        tick();
        chk("rstmid_wr1", 32'(wr_addr), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_wr_en", 32'(wr_en), 32'd0);
        chk("rstmid_wr_addr", 32'(wr_addr), 32'd0);
        chk("rstmid_wr_data", 32'(wr_data), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_rand_en", 32'(rand_en), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        fill_random_seq();
        run_fill(3'd3, 3'd3, 4'd15, "refill");

        // max_val = 0: only zeros ever written
        fill_random_seq();
        run_fill(3'd2, 3'd2, 4'd0, "max0");

        // randomized fills
        for (int t = 0; t < 6; t++) begin
            fill_random_seq();
            run_fill(3'($urandom_range(1, 5)), 3'($urandom_range(1, 5)),
                     4'($urandom_range(0, 15)), "rnd");
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/rand_matrix_ctrl.md
# rand_matrix_ctrl

Sequencer that fills a matrix with bounded random elements. It draws 4-bit values from the free-running LFSR random source and range-limits each one to 0..max_val. Accepted values are written row-major into matrix storage through a simple write port. It sits between the user-input FSM, which supplies dimensions and a start pulse, and the matrix storage RAM used by the calculator's generate mode.

## Interface
- MAX_DIM, 5, largest legal row/column count
- DATA_W, 4, element width; must equal random source width
- ADDR_W, 5, write-address width; must hold MAX_DIM*MAX_DIM-1
- RETRY_MAX, 7, consecutive rejections tolerated before a forced write
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  cancels an in-progress fill
- rows  in  3  row count, legal 1..MAX_DIM
- cols  in  3  column count, legal 1..MAX_DIM
- max_val  in  DATA_W  inclusive upper bound of element values
- rand_in  in  DATA_W  current random value from LFSR
- rand_en  out  1  advance request to LFSR; high in GEN state
- wr_en  out  1  one-cycle write strobe to matrix storage
- wr_addr  out  ADDR_W  packed row-major address, r*cols+c
- wr_data  out  DATA_W  element value
- busy  out  1  high from GEN entry through the DONE cycle
- done  out  1  one-cycle pulse after the last element write
- err  out  1  one-cycle pulse on start with illegal dimensions

## Operation
- States: IDLE, GEN, DONE.
- IDLE, start=1, rows and cols in 1..MAX_DIM: latch rows, cols, max_val; clear element counter, address and retry counter; go to GEN.
- IDLE, start=1, rows or cols equal to 0 or above MAX_DIM: pulse err for one cycle and stay in IDLE. No write is issued.
- GEN, each cycle: sample rand_in.
  - Accept when rand_in <= latched max_val.
  - On reject with retry_cnt < RETRY_MAX: increment retry_cnt and issue no write.
  - On reject with retry_cnt == RETRY_MAX: force a write of rand_in & max_val. The bitwise AND always yields a value <= max_val.
- On an accepted or forced sample: register wr_en=1, wr_addr = current address, wr_data = value. Then clear retry_cnt and increment the address.
- The last element is address rows*cols-1. Its write moves the FSM to DONE.
- DONE: done=1 and busy=1 for one cycle, then return to IDLE.
- abort=1 in GEN or DONE: return to IDLE on the next edge. No further wr_en, no done pulse. Abort has priority over a same-cycle write.
- start while busy is ignored. Latched parameters do not change mid-fill.
- max_val=15: every sample is accepted. max_val=0: only 0 is accepted; a forced write produces 0.

## Timing
- Reset: state=IDLE. wr_en, wr_addr, wr_data, busy, done, err, rand_en, counters all 0. Takes effect asynchronously, including mid-GEN.
- wr_en, wr_addr, wr_data, done, err, busy are registered. rand_en decodes directly from state.
- start sampled at edge 0 → GEN after edge 0. The first rand_in sample is taken at edge 1, so the first wr_en is high in the cycle after edge 1.
- Best case: one element per cycle. N = rows*cols elements → last wr_en after edge N, done after edge N+1, IDLE after edge N+2.
- Each reject adds one cycle. Worst case per element is RETRY_MAX+1 cycles.
- err is high in the cycle following the sampling edge.

## Test plan
- rows=2, cols=3, max_val=15, rand_in=1,2,3,4,5,6 on successive cycles → wr_en on 6 consecutive cycles, addr 0..5, data 1..6. done 1 cycle after the last write; busy spans 7 cycles.
- rows=1, cols=1, max_val=5, rand_in=9,9,3 → two cycles without wr_en, then a write of data 3 at addr 0. Then done.
- rows=1, cols=1, max_val=5, rand_in held at 14 → 7 rejections, then a forced write of data 4 (14&5) at addr 0 on the 8th sample.
- start with rows=0, cols=3, and again with rows=2, cols=6 → err pulses once each. wr_en and busy stay 0.
- rows=2, cols=2, max_val=15: assert abort after the 3rd write, and pulse start while busy → no 4th write, no done, state returns to IDLE, and the extra start is ignored.
- Assert rst after 2 writes of a 3x3 fill → all outputs 0 immediately. A fresh start then refills from addr 0.
